stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clock frequency in Hz; SHALL only be passed through for documentation/debounce scaling.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable synchronized samples required to accept a button level change.
REQ-003 clk  input  1  system clock; all logic SHALL be clocked on the rising edge of clk only.
REQ-004 reset  input  1  reset; it is synchronous and active-high.
REQ-005 btn_start_stop  input  1  raw, asynchronous start/stop pushbutton.
REQ-006 btn_clear  input  1  raw, asynchronous clear pushbutton.
REQ-007 btn_lap  input  1  raw, asynchronous lap/split pushbutton.
REQ-008 time_reading  input  8  live counter value {tens BCD, ones BCD}.
REQ-009 init_regs  output  1  registered; clears the seconds counter.
REQ-010 count_enabled  output  1  registered; enables seconds counter advance.
REQ-011 display  output  8  value for the seven-segment driver.
REQ-012 lap_valid  output  1  high while display shows a frozen lap value.
REQ-013 state  output  2  current FSM state encoding, for LEDs.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose accepted level changes only after DEBOUNCE_CYCLES consecutive samples differ from it.
REQ-015 Each accepted 0->1 level change SHALL generate a press pulse exactly one cycle wide; releases generate nothing; a held button generates exactly one pulse.
REQ-016 Press pulse SHALL occur between DEBOUNCE_CYCLES and DEBOUNCE_CYCLES+3 cycles after a clean raw rising edge; glitches shorter than DEBOUNCE_CYCLES SHALL produce no pulse.
REQ-017 FSM states SHALL be IDLE=2'b00, RUN=2'b01, LAP=2'b10, PAUSE=2'b11.
REQ-018 Simultaneous press pulses SHALL be prioritised start_stop > clear > lap; only the winner is acted on, the others are discarded.
REQ-019 IDLE: start -> RUN; clear -> stay IDLE with one-cycle init_regs pulse; lap ignored.
REQ-020 RUN: start -> PAUSE; lap -> LAP and capture time_reading into lap register in the same cycle; clear ignored.
REQ-021 LAP: lap -> RUN; start -> PAUSE (lap released); clear ignored; a further lap capture SHALL require returning to RUN first.
REQ-022 PAUSE: start -> RUN; clear -> IDLE with one-cycle init_regs pulse; lap ignored.
REQ-023 count_enabled SHALL be 1 exactly when the registered state is RUN or LAP; it updates the cycle after the accepted press pulse.
REQ-024 init_regs SHALL be high for exactly one cycle, the cycle after the accepted clear pulse, and in every cycle reset is high.
REQ-025 display SHALL equal the lap register while state is LAP, otherwise time_reading (combinational mux); lap_valid SHALL equal (state==LAP).
REQ-026 Counter wrap (time_reading 8'h59 -> 8'h00) SHALL NOT affect state; lap register holds its value across wrap.

Reset
REQ-027 While reset is high at a clock edge: state=IDLE, count_enabled=0, init_regs=1, lap register=8'h00, synchronizers, debounce counters and accepted levels=0.
REQ-028 Reset asserted mid-operation (any state, any debounce in progress) SHALL take effect at the next edge and discard pending presses; a button held through reset release SHALL produce one pulse after debounce.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-029 Reset 2 cycles -> init_regs=1 both cycles, then state=00, count_enabled=0, init_regs=0, display=time_reading.
REQ-030 From IDLE hold btn_start_stop 10 cycles -> exactly one pulse, state=01, count_enabled=1 within 4-7+1 cycles of press; release causes no change.
REQ-031 RUN, time_reading=8'h23, press lap -> state=10, display=8'h23, lap_valid=1 while time_reading advances to 8'h24; press lap -> state=01, display=8'h24.
REQ-032 RUN -> start (PAUSE, count_enabled=0) -> clear -> init_regs high exactly 1 cycle, state=00; clear in RUN -> no init_regs pulse.
REQ-033 Start and lap pressed same cycle in RUN -> state=11 only, lap register unchanged; 2-cycle glitch on btn_clear -> no pulse.
REQ-034 Reset asserted in LAP with lap=8'h41 -> state=00, lap_valid=0, count_enabled=0, lap register=8'h00.

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between the stopwatch front panel / counter and the control block.
// The master side drives buttons and the live count; the slave side is the controller.
interface stopwatch_ctrl_if;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic [7:0] time_reading;
  logic       init_regs;
  logic       count_enabled;
  logic [7:0] display;
  logic       lap_valid;
  logic [1:0] state;

  modport master (
    output btn_start_stop, btn_clear, btn_lap, time_reading,
    input  init_regs, count_enabled, display, lap_valid, state
  );

  modport slave (
    input  btn_start_stop, btn_clear, btn_lap, time_reading,
    output init_regs, count_enabled, display, lap_valid, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronizes and debounces three pushbuttons, turns accepted
// presses into one-cycle pulses and runs the IDLE/RUN/LAP/PAUSE control FSM.
module stopwatch_ctrl #(
  parameter int unsigned CLK_FREQ        = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  bus
);

  // A zero clock or zero debounce setting degenerates to accepting every synchronized change.
  localparam int unsigned DB_CYCLES = (CLK_FREQ != 0 && DEBOUNCE_CYCLES != 0) ? DEBOUNCE_CYCLES : 1;
  localparam int unsigned CNT_W     = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  localparam int BTN_START = 0;
  localparam int BTN_CLEAR = 1;
  localparam int BTN_LAP   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_START,
    CMD_CLEAR,
    CMD_LAP
  } cmd_t;

  logic [2:0]       btn_raw;
  logic [2:0]       sync_meta;
  logic [2:0]       sync_q;
  logic [2:0]       level_q;
  logic [2:0]       level_prev;
  logic [CNT_W-1:0] db_cnt [3];
  logic [2:0]       press;
  cmd_t             cmd;

  state_t     state_q;
  logic       count_enabled_q;
  logic       init_regs_q;
  logic [7:0] lap_reg;

  assign btn_raw = {bus.btn_lap, bus.btn_clear, bus.btn_start_stop};

  // NOTE: every register uses <= so all flops sample their inputs from the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_q    <= sync_meta;
    end
  end

  // Accepted level flips on the DB_CYCLES-th consecutive sample that disagrees with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q    <= '0;
      level_prev <= '0;
      // NOTE: the counter array is plain flops, so it is cleared with the rest of the state.
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      level_prev <= level_q;
      for (int i = 0; i < 3; i++) begin
        if (sync_q[i] == level_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          level_q[i] <= sync_q[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = level_q & ~level_prev;

  // Only the highest-priority simultaneous press survives; the rest are dropped.
  always_comb begin
    cmd = CMD_NONE;
    if (press[BTN_START])      cmd = CMD_START;
    else if (press[BTN_CLEAR]) cmd = CMD_CLEAR;
    else if (press[BTN_LAP])   cmd = CMD_LAP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      count_enabled_q <= 1'b0;
      init_regs_q     <= 1'b1;
      lap_reg         <= '0;
    end else begin
      init_regs_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd == CMD_START) begin
            state_q         <= RUN;
            count_enabled_q <= 1'b1;
          end else if (cmd == CMD_CLEAR) begin
            init_regs_q <= 1'b1;
          end
        end
        RUN: begin
          if (cmd == CMD_START) begin
            state_q         <= PAUSE;
            count_enabled_q <= 1'b0;
          end else if (cmd == CMD_LAP) begin
            state_q <= LAP;
            lap_reg <= bus.time_reading;
          end
        end
        LAP: begin
          if (cmd == CMD_START) begin
            state_q         <= PAUSE;
            count_enabled_q <= 1'b0;
          end else if (cmd == CMD_LAP) begin
            state_q <= RUN;
          end
        end
        PAUSE: begin
          if (cmd == CMD_START) begin
            state_q         <= RUN;
            count_enabled_q <= 1'b1;
          end else if (cmd == CMD_CLEAR) begin
            state_q     <= IDLE;
            init_regs_q <= 1'b1;
          end
        end
        default: begin
          state_q         <= IDLE;
          count_enabled_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.state         = state_q;
  assign bus.count_enabled = count_enabled_q;
  assign bus.init_regs     = init_regs_q;
  assign bus.lap_valid     = (state_q == LAP);
  assign bus.display       = (state_q == LAP) ? lap_reg : bus.time_reading;

endmodule
